// File: rtl/instr_encoder.sv
// instr_encoder: encodes field requests into 32-bit instruction words and writes them through a FIFO to sequential memory addresses
// Ports: clk/rst_n clock and async active-low reset; start/base_addr open a session at base_addr; finish ends it;
// in_* request handshake and fields; out_* memory write handshake (addr, data); busy/done/err/word_count status.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] mem [DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] addr;
  logic [31:0] word;
  logic empty, full, legal, imm12_ok, imm16_ok, accept, push, pop;
  // immediates fit when all bits above the sign position equal the sign
  assign imm12_ok = &in_imm[31:11] | ~|in_imm[31:11];
  assign imm16_ok = &in_imm[31:15] | ~|in_imm[31:15];
  assign legal = in_kind == 2'd0 ? imm12_ok : imm16_ok && (in_kind != 2'd3 || in_opcode[4]);
  // in_kind[1] distinguishes R2-imm (2) from R2-offset (1) in bit 0
  assign word = in_kind == 2'd0 ? {1'b0, in_op, 1'b0, in_rd, in_rs1, in_rs2, in_imm[11:0]} :
                in_kind == 2'd3 ? {in_opcode, in_rd, in_rs1, in_imm[15:0], 1'b0} :
                {1'b0, in_op, 1'b1, in_rd, in_rs1, in_imm[15:0], in_kind[1]};
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr[PW] != rd_ptr[PW] && wr_ptr[PW-1:0] == rd_ptr[PW-1:0];
  assign accept = in_valid && in_ready;
  assign push = accept && legal;
  assign pop = out_valid && out_ready;
  assign out_valid = !empty;
  assign out_data = mem[rd_ptr[PW-1:0]];
  assign out_addr = addr;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE && start ? RUN :
               state == RUN && finish ? DRAIN :
               state == DRAIN && empty ? DONE :
               state == DONE ? IDLE : state;
    in_ready = state == RUN && !full;
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      addr <= '0;
      word_count <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (state == IDLE && start) begin
        addr <= base_addr;
        word_count <= '0;
        err <= 1'b0;
      end else begin
        if (pop) begin
          addr <= addr + 1'b1;
          word_count <= word_count + 1'b1;
        end
        if ((accept && !legal) || (pop && &addr)) err <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= word;
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed stimulus with a queue-based reference model checked every cycle plus literal spot checks
module tb_instr_encoder;
  logic clk = 0, rst_n = 0, start = 0, finish = 0, in_valid = 0, out_ready = 0;
  logic [9:0] base_addr = '0;
  logic [1:0] in_kind = '0;
  logic [2:0] in_op = '0;
  logic [4:0] in_opcode = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic in_ready, out_valid, busy, done, err;
  logic [9:0] out_addr;
  logic [31:0] out_data;
  logic [10:0] word_count;
  int n_cmp = 0, n_bad = 0;
  int m_state = 0, m_addr = 0, m_cnt = 0;
  bit m_err = 0;
  logic [31:0] mq[$];

  instr_encoder #(.DEPTH(4), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_op(in_op),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input int k, input int op, input int opc, input int rd,
                                      input int rs1, input int rs2, input int imm);
    if (k == 0) return 32'(op * 2**28 + rd * 2**22 + rs1 * 2**17 + rs2 * 2**12 + (imm & 'hFFF));
    if (k == 3) return 32'(opc * 2**27 + rd * 2**22 + rs1 * 2**17 + (imm & 'hFFFF) * 2);
    return 32'(op * 2**28 + 2**27 + rd * 2**22 + rs1 * 2**17 + (imm & 'hFFFF) * 2 + (k == 2 ? 1 : 0));
  endfunction

  function automatic bit ok(input int k, input int opc, input int imm);
    if (k == 0) return imm >= -2048 && imm <= 2047;
    return imm >= -32768 && imm <= 32767 && (k != 3 || opc >= 16);
  endfunction

  always @(negedge clk) begin
    int sz;
    bit acc, pop;
    if (!rst_n) begin
      m_state = 0; m_addr = 0; m_cnt = 0; m_err = 0;
      mq.delete();
    end
    sz = mq.size();
    chk("in_ready", in_ready, m_state == 1 && sz < 4);
    chk("out_valid", out_valid, sz > 0);
    chk("out_addr", out_addr, m_addr);
    if (sz > 0) chk("out_data", out_data, mq[0]);
    chk("busy", busy, m_state != 0);
    chk("done", done, m_state == 3);
    chk("err", err, m_err);
    chk("word_count", word_count, m_cnt);
    if (rst_n) begin
      acc = in_valid && m_state == 1 && sz < 4;
      pop = sz > 0 && out_ready;
      if (m_state == 0 && start) begin
        m_addr = int'(base_addr); m_cnt = 0; m_err = 0;
      end
      if (pop) begin
        if (m_addr == 1023) m_err = 1;
        void'(mq.pop_front());
        m_addr = (m_addr + 1) % 1024;
        m_cnt++;
      end
      if (acc) begin
        if (ok(in_kind, in_opcode, int'($signed(in_imm))))
          mq.push_back(enc(in_kind, in_op, in_opcode, in_rd, in_rs1, in_rs2, int'($signed(in_imm))));
        else m_err = 1;
      end
      case (m_state)
        0: if (start) m_state = 1;
        1: if (finish) m_state = 2;
        2: if (sz == 0) m_state = 3;
        default: m_state = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int k, input int op, input int opc, input int rd, input int rs1,
                     input int rs2, input int imm);
    bit got = 0;
    in_kind = 2'(k); in_op = 3'(op); in_opcode = 5'(opc);
    in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = 32'(imm);
    in_valid = 1;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = in_ready;
      step();
    end
    chk("req_accepted", got, 1);
    in_valid = 0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    chk("done_seen", seen, 1);
    step();
    chk("done_single", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic pulse_start(input logic [9:0] base, input logic fin);
    base_addr = base; start = 1; finish = fin;
    step();
    start = 0; finish = 0;
  endtask

  initial begin
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_word_count", word_count, 0);
    rst_n = 1;
    step();
    out_ready = 1;
    pulse_start(10'h010, 0);
    req(0, 2, 0, 3, 1, 2, -1);
    chk("r3_valid", out_valid, 1);
    chk("r3_addr", out_addr, 10'h010);
    chk("r3_data", out_data, 32'h20C22FFF);
    step();
    chk("r3_count", word_count, 1);
    req(2, 0, 0, 5, 5, 0, 100);
    chk("r2imm_data", out_data, 32'h094A00C9);
    req(0, 1, 0, 1, 2, 3, 2048);
    chk("illegal_r3_valid", out_valid, 0);
    chk("illegal_r3_err", err, 1);
    req(3, 0, 5'b00110, 1, 2, 0, 7);
    chk("illegal_other_count", word_count, 2);
    req(3, 0, 5'b10011, 7, 8, 0, -5);
    req(1, 4, 0, 9, 10, 0, -32768);
    req(0, 7, 0, 31, 30, 29, -2048);
    step();
    out_ready = 0;
    req(0, 1, 0, 1, 1, 1, 1);
    req(2, 2, 0, 2, 2, 0, 32767);
    req(1, 3, 0, 3, 3, 0, 3);
    req(3, 0, 5'b11111, 4, 4, 0, 4);
    chk("full_in_ready", in_ready, 0);
    fork
      begin
        repeat (3) @(posedge clk);
        #2 out_ready = 1;
      end
    join_none
    req(0, 5, 0, 5, 5, 5, 5);
    repeat (2) step();
    finish = 1;
    step();
    finish = 0;
    wait_done();
    pulse_start(10'h3FF, 1);
    chk("start_finish_run", busy, 1);
    req(0, 1, 0, 2, 3, 4, 10);
    req(2, 6, 0, 6, 6, 0, -100);
    finish = 1;
    step();
    finish = 0;
    wait_done();
    chk("wrap_err", err, 1);
    chk("wrap_count", word_count, 2);
    out_ready = 0;
    pulse_start(10'h100, 0);
    req(0, 1, 0, 1, 1, 1, 1);
    req(0, 2, 0, 2, 2, 2, 2);
    req(0, 3, 0, 3, 3, 3, 3);
    step();
    rst_n = 0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_count", word_count, 0);
    repeat (2) step();
    rst_n = 1;
    out_ready = 1;
    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The parameter list SHALL be: DEPTH, default 4, entries in the encoded-word FIFO (power of two, at least 2).
REQ-002 The parameter list SHALL also include: ADDR_W, default 10, width of the instruction-memory word address.
REQ-003 The ports SHALL be, in order:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  session start pulse.
- base_addr  in  ADDR_W  first write address, sampled on start.
- finish  in  1  end-of-stream pulse.
- in_valid  in  1  field request valid.
- in_ready  out  1  field request accepted when in_valid and in_ready are both high.
- in_kind  in  2  0=R3, 1=R2-offset, 2=R2-imm, 3=OTHER.
- in_op  in  3  ALU/FPU operation.
- in_opcode  in  5  OTHER-class opcode.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  signed immediate.
- out_valid  out  1  memory write request.
- out_ready  in  1  memory accepts the write.
- out_addr  out  ADDR_W  write address.
- out_data  out  32  encoded instruction word.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error flag.
- word_count  out  ADDR_W+1  words written this session.

Function
REQ-004 The block SHALL encode each accepted request combinationally into 32-bit word W and push W into the FIFO on the acceptance cycle.
- R3: W[31]=0, W[30:28]=in_op, W[27]=0, W[26:22]=rd, W[21:17]=rs1, W[16:12]=rs2, W[11:0]=in_imm[11:0].
- R2-offset and R2-imm: W[31]=0, W[30:28]=in_op, W[27]=1, W[26:22]=rd, W[21:17]=rs1, W[16:1]=in_imm[15:0], W[0]=0 for R2-offset, 1 for R2-imm.
- OTHER: W[31:27]=in_opcode, W[26:22]=rd, W[21:17]=rs1, W[16:1]=in_imm[15:0], W[0]=0.
REQ-005 The following requests SHALL be illegal:
- R3 with in_imm outside the signed 12-bit range [-2048, 2047].
- R2-offset, R2-imm or OTHER with in_imm outside the signed 16-bit range [-32768, 32767].
- OTHER with in_opcode[4]=0.
REQ-006 An illegal request SHALL still be accepted (handshake completes), SHALL NOT be pushed, and SHALL set err.
REQ-007 The FSM SHALL have states IDLE, RUN, DRAIN and DONE, with these transitions:
- IDLE->RUN on start.
- RUN->DRAIN on finish.
- DRAIN->DONE when the FIFO is empty.
- DONE->IDLE unconditionally after one cycle.
REQ-008 On start in IDLE, the block SHALL load the write address from base_addr and clear word_count and err.
REQ-009 start SHALL be ignored outside IDLE, and finish SHALL be ignored outside RUN.
REQ-010 If start and finish are high in the same cycle in IDLE, the block SHALL enter RUN and ignore finish.
REQ-011 in_ready SHALL equal (state==RUN) and not FIFO-full; there is no pass-through when the FIFO is full.
REQ-012 The acceptance cycle of finish SHALL still accept a request presented in that cycle.
REQ-013 out_valid SHALL equal FIFO not-empty, out_data SHALL equal the FIFO head, and out_addr SHALL equal the current write address.
REQ-014 On out_valid and out_ready, the block SHALL pop the FIFO, increment the write address (wrapping modulo 2^ADDR_W) and increment word_count.
REQ-015 The wrap from all-ones to 0 SHALL set err.
REQ-016 Latency SHALL be exactly 1 cycle from request acceptance to out_valid when the FIFO was empty.
REQ-017 A simultaneous push and pop SHALL leave the occupancy unchanged and preserve order.
REQ-018 out_valid, out_data and out_addr SHALL be held stable while out_valid is high and out_ready is low.
REQ-019 done SHALL be high for exactly the single cycle in DONE.
REQ-020 word_count and err SHALL hold their values in IDLE until the next start.

Reset
REQ-021 While rst_n is low, the block SHALL asynchronously force:
- state to IDLE.
- FIFO to empty.
- write address to 0.
- word_count to 0.
- err, done, busy, in_ready and out_valid to 0.
REQ-022 Reset asserted mid-session SHALL discard all FIFO contents with no further write.
REQ-023 After rst_n deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-024 R3 encoding: start with base_addr=0x010; send R3 op=2, rd=3, rs1=1, rs2=2, imm=-1 with out_ready=1 -> next cycle out_valid=1, out_addr=0x010, out_data=0x20C22FFF, then word_count=1.
REQ-025 R2-imm encoding: send R2-imm op=0, rd=5, rs1=5, imm=100 -> out_data=0x094A00C9.
REQ-026 Illegal request: send R3 imm=2048, or OTHER opcode=5'b00110 -> request accepted, no out_valid, err=1, word_count unchanged.
REQ-027 Backpressure: out_ready=0, send 5 back-to-back requests -> in_ready low after the 4th accept; raise out_ready -> the 4 words are written in order at consecutive addresses, then the 5th is accepted.
REQ-028 Wrap and finish: base_addr=0x3FF; send 2 words, then finish -> writes at 0x3FF and 0x000, err=1, DRAIN until empty, one done pulse, busy=0.
REQ-029 Reset mid-operation: FIFO holding 3 words with out_ready=0; pulse rst_n low -> out_valid=0 immediately, state IDLE, word_count=0, no writes after reset is released.
